// File: rtl/lcd_msg_arbiter.sv
// Round-robin arbiter sharing the LCD text register between two message sources.
// Every granted message is written once and then held for a minimum dwell time.
module lcd_msg_arbiter #(
  parameter int unsigned DATA_WIDTH   = 224,
  parameter int unsigned DWELL_CYCLES = 50000000,
  parameter int unsigned CNT_WIDTH    = 26
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  req0,
  input  logic [DATA_WIDTH-1:0] msg0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] msg1,
  output logic                  grant0,
  output logic                  grant1,
  output logic [DATA_WIDTH-1:0] disp_d,
  output logic                  disp_we,
  output logic                  owner,
  output logic                  busy
);

  localparam int unsigned NUM_CHARS = DATA_WIDTH / 8;
  localparam logic [DATA_WIDTH-1:0] SPACES = {NUM_CHARS{8'h20}};
  localparam logic [CNT_WIDTH-1:0] DWELL_LAST = CNT_WIDTH'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DWELL = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ptr_q, ptr_d;
  logic                  owner_q, owner_d;
  logic                  busy_q, busy_d;
  logic                  we_q, we_d;
  logic                  grant0_q, grant0_d;
  logic                  grant1_q, grant1_d;
  logic [DATA_WIDTH-1:0] disp_data_q, disp_data_d;

  // State and registered outputs; reset also restores the blank display image.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      we_q        <= 1'b0;
      grant0_q    <= 1'b0;
      grant1_q    <= 1'b0;
      disp_data_q <= SPACES;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      we_q        <= we_d;
      grant0_q    <= grant0_d;
      grant1_q    <= grant1_d;
      disp_data_q <= disp_data_d;
    end
  end

  // Next-state and next-output logic; pulses default low, held values default to hold.
  always_comb begin
    logic win;
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    disp_data_d = disp_data_q;
    we_d        = 1'b0;
    grant0_d    = 1'b0;
    grant1_d    = 1'b0;
    win         = (req0 & req1) ? ptr_q : req1;

    case (state_q)
      ST_INIT: begin
        state_d     = ST_IDLE;
        we_d        = 1'b1;
        disp_data_d = SPACES;
      end
      ST_IDLE: begin
        if (req0 | req1) begin
          state_d     = ST_LOAD;
          we_d        = 1'b1;
          busy_d      = 1'b1;
          owner_d     = win;
          ptr_d       = ~win;
          grant0_d    = ~win;
          grant1_d    = win;
          disp_data_d = win ? msg1 : msg0;
        end
      end
      ST_LOAD: begin
        state_d = ST_DWELL;
        cnt_d   = DWELL_LAST;
      end
      ST_DWELL: begin
        // Counter runs DWELL_LAST..0, giving exactly DWELL_CYCLES cycles here.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign grant0  = grant0_q;
  assign grant1  = grant1_q;
  assign disp_d  = disp_data_q;
  assign disp_we = we_q;
  assign owner   = owner_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Scoreboard bench for lcd_msg_arbiter: a timestamp-based reference model predicts
// every display write; a negedge monitor pops and compares.
module tb_lcd_msg_arbiter;

  localparam int unsigned DW    = 224;
  localparam int unsigned DWELL = 4;
  localparam logic [DW-1:0] SPACES  = {28{8'h20}};
  localparam logic [DW-1:0] ISHMAEL = {120'h43616c6c206d65206973686d61656c, {13{8'h20}}};

  logic          clk = 1'b0;
  logic          clrn;
  logic          req0, req1;
  logic [DW-1:0] msg0, msg1;
  logic          grant0, grant1, disp_we, owner, busy;
  logic [DW-1:0] disp_d;

  lcd_msg_arbiter #(.DATA_WIDTH(DW), .DWELL_CYCLES(DWELL), .CNT_WIDTH(3)) dut (
    .clk(clk), .clrn(clrn),
    .req0(req0), .msg0(msg0), .req1(req1), .msg1(msg1),
    .grant0(grant0), .grant1(grant1),
    .disp_d(disp_d), .disp_we(disp_we), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          g0;
    bit          g1;
    bit          own;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exq[$];
  int            compared   = 0;
  int            mismatched = 0;
  int            writes_seen = 0;

  // Reference model: grants happen only at edges at or after idle_from.
  int            cyc = 0;
  int            idle_from = 0;
  int            busy_end = -1;
  bit            need_clear = 1'b0;
  bit            pref = 1'b0;
  bit            valid = 1'b0;
  bit            exp_busy = 1'b0;
  bit            exp_owner = 1'b0;
  logic [DW-1:0] exp_disp = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit win;
    cyc++;
    if (!clrn) begin
      valid      = 1'b1;
      need_clear = 1'b1;
      pref       = 1'b0;
      exp_owner  = 1'b0;
      exp_busy   = 1'b0;
      exp_disp   = SPACES;
      busy_end   = -1;
      exq.delete();
    end else if (valid) begin
      if (cyc == busy_end) exp_busy = 1'b0;
      if (need_clear) begin
        need_clear = 1'b0;
        exq.push_back('{g0: 1'b0, g1: 1'b0, own: exp_owner, data: SPACES});
        idle_from = cyc + 1;
      end else if (cyc >= idle_from && (req0 || req1)) begin
        win       = (req0 && req1) ? pref : req1;
        exp_disp  = win ? msg1 : msg0;
        exp_owner = win;
        exp_busy  = 1'b1;
        pref      = !win;
        busy_end  = cyc + DWELL + 1;
        idle_from = cyc + DWELL + 2;
        exq.push_back('{g0: !win, g1: win, own: win, data: exp_disp});
      end
    end
  end

  // Monitor: per-cycle state checks plus scoreboard pop on every display write.
  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      chk("busy", DW'(busy), DW'(exp_busy));
      chk("owner", DW'(owner), DW'(exp_owner));
      chk("disp_d_hold", disp_d, exp_disp);
      chk("grant_exclusive", DW'(grant0 & grant1), DW'(0));
      if (disp_we) begin
        writes_seen++;
        if (exq.size() == 0) begin
          chk("unexpected_write", DW'(1), DW'(0));
        end else begin
          e = exq.pop_front();
          chk("write_grant0", DW'(grant0), DW'(e.g0));
          chk("write_grant1", DW'(grant1), DW'(e.g1));
          chk("write_owner", DW'(owner), DW'(e.own));
          chk("write_data", disp_d, e.data);
        end
      end else begin
        chk("idle_grants", DW'({grant0, grant1}), DW'(0));
        chk("missing_write", DW'(exq.size()), DW'(0));
      end
    end
  end

  function automatic logic [DW-1:0] rnd_msg();
    logic [DW-1:0] r = '0;
    for (int i = 0; i < 7; i++) r = {r[DW-33:0], 32'($urandom())};
    return r;
  endfunction

  bit got0, got1;

  // mode 0: drop request on grant; 1: keep both requesting; 2: random traffic.
  task automatic cyc_drive(input int mode);
    @(negedge clk);
    got0 = grant0;
    got1 = grant1;
    if (mode == 1) begin
      if (grant0 || !req0) begin req0 = 1'b1; msg0 = rnd_msg(); end
      if (grant1 || !req1) begin req1 = 1'b1; msg1 = rnd_msg(); end
    end else begin
      if (grant0) req0 = 1'b0;
      if (grant1) req1 = 1'b0;
      if (mode == 2) begin
        clrn = ($urandom_range(199) != 0);
        if (req0 && !grant0 && $urandom_range(15) == 0) req0 = 1'b0;
        else if (!req0 && $urandom_range(5) == 0) begin req0 = 1'b1; msg0 = rnd_msg(); end
        if (req1 && !grant1 && $urandom_range(15) == 0) req1 = 1'b0;
        else if (!req1 && $urandom_range(5) == 0) begin req1 = 1'b1; msg1 = rnd_msg(); end
      end
    end
  endtask

  task automatic wait_grant(input bit n, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc_drive(0);
      seen = n ? got1 : got0;
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL grant%0d_timeout: got none expected grant within %0d cycles", n, budget);
    end
  endtask

  initial begin
    clrn = 1'b0; req0 = 1'b0; req1 = 1'b0; msg0 = '0; msg1 = '0;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (3) cyc_drive(0);

    // Single request with a known message.
    req0 = 1'b1; msg0 = ISHMAEL;
    wait_grant(0, 20);
    repeat (8) cyc_drive(0);

    // Continuous contention: strict alternation expected.
    repeat (26) cyc_drive(1);
    req0 = 1'b0; req1 = 1'b0;
    repeat (8) cyc_drive(0);

    // Request raised during another owner's dwell.
    req0 = 1'b1; msg0 = rnd_msg();
    wait_grant(0, 20);
    req1 = 1'b1; msg1 = rnd_msg();
    wait_grant(1, 20);
    repeat (8) cyc_drive(0);

    // Short pulse inside a dwell is never served.
    req0 = 1'b1; msg0 = rnd_msg();
    wait_grant(0, 20);
    cyc_drive(0);
    req1 = 1'b1; msg1 = rnd_msg();
    repeat (2) cyc_drive(0);
    req1 = 1'b0;
    repeat (10) cyc_drive(0);

    // Reset mid-dwell with a held request.
    req0 = 1'b1; msg0 = rnd_msg();
    wait_grant(0, 20);
    repeat (2) cyc_drive(0);
    req1 = 1'b1; msg1 = rnd_msg();
    clrn = 1'b0;
    cyc_drive(0);
    clrn = 1'b1;
    wait_grant(1, 20);
    repeat (8) cyc_drive(0);

    // Random traffic with occasional resets.
    repeat (3000) cyc_drive(2);
    clrn = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (12) cyc_drive(0);

    chk("queue_drained", DW'(exq.size()), DW'(0));
    compared++;
    if (writes_seen < 50) begin
      mismatched++;
      $display("FAIL write_count: got %0d expected at least 50", writes_seen);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
